// File: rtl/lf_sample_ssp_tx_pkg.sv
// Shared SSP transmitter definitions: FSM encodings, word size and the
// MSB-first bit ordering used by every SSP serialiser in the LF paths.
package lf_sample_ssp_tx_pkg;

    localparam int SSP_BITS  = 8;
    localparam int SSP_MSB   = SSP_BITS - 1;
    localparam int SSP_CNT_W = $clog2(SSP_BITS);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ssp_state_t;

    // MSB-first: the bit on the wire is always the top of the shift register.
    function automatic logic ssp_first_bit(input logic [SSP_BITS-1:0] word);
        return word[SSP_MSB];
    endfunction

    function automatic logic [SSP_BITS-1:0] ssp_advance(input logic [SSP_BITS-1:0] word);
        return {word[SSP_MSB-1:0], 1'b0};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with asynchronous reset. A push while full is
// accepted only when a pop frees the slot in the same cycle.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_level == LW'(DEPTH));
    assign empty     = (r_level == '0);
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign dout      = r_mem[r_rptr];
    assign level     = r_level;

    // Storage is not reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/lf_sample_ssp_tx.sv
// Captures filtered LF samples into a FIFO and serialises them MSB-first on
// the SSP lines, back-to-back while samples are queued.
module lf_sample_ssp_tx
    import lf_sample_ssp_tx_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int SSP_DIV = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   data_rdy,
    input  logic [7:0]             adc_filtered,
    output logic                   ssp_clk,
    output logic                   ssp_frame,
    output logic                   ssp_din,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output ssp_state_t             dbg_state
);

    localparam int DW = (SSP_DIV > 1) ? $clog2(SSP_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SSP_DIV - 1);

    ssp_state_t              r_state;
    ssp_state_t              w_state_nxt;
    logic [SSP_BITS-1:0]     r_shift;
    logic [SSP_BITS-1:0]     w_shift_nxt;
    logic [SSP_CNT_W-1:0]    r_bitcnt;
    logic [SSP_CNT_W-1:0]    w_bitcnt_nxt;
    logic [DW-1:0]           r_div;
    logic [DW-1:0]           w_div_nxt;
    logic                    r_sclk;
    logic                    w_sclk_nxt;
    logic                    r_frame;
    logic                    w_frame_nxt;
    logic                    r_overflow;

    logic                    w_wr;
    logic                    w_pop;
    logic                    w_load;
    logic                    w_tick;
    logic [7:0]              w_dout;
    logic                    w_full;
    logic                    w_empty;

    assign w_wr = data_rdy && enable;

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SSP_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_wr),
        .pop   (w_pop),
        .din   (adc_filtered),
        .dout  (w_dout),
        .level (fifo_level),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_tick = (r_div == DIV_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_div_nxt    = r_div;
        w_sclk_nxt   = r_sclk;
        w_frame_nxt  = r_frame;
        w_pop        = 1'b0;
        w_load       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!w_tick) begin
                    w_div_nxt = r_div + DW'(1);
                end else begin
                    w_div_nxt  = '0;
                    w_sclk_nxt = ~r_sclk;
                    // Data only moves on the falling edge, centring each bit on the rise.
                    if (r_sclk) begin
                        if (r_bitcnt != '0) begin
                            w_shift_nxt  = ssp_advance(r_shift);
                            w_bitcnt_nxt = r_bitcnt - SSP_CNT_W'(1);
                            w_frame_nxt  = 1'b0;
                        end else if (!w_empty) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_shift_nxt = '0;
                            w_frame_nxt = 1'b0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_pop        = 1'b1;
            w_shift_nxt  = w_dout;
            w_frame_nxt  = 1'b1;
            w_bitcnt_nxt = SSP_CNT_W'(SSP_MSB);
            w_div_nxt    = '0;
            w_sclk_nxt   = 1'b0;
            w_state_nxt  = ST_SHIFT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_div    <= '0;
            r_sclk   <= 1'b0;
            r_frame  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_div    <= w_div_nxt;
            r_sclk   <= w_sclk_nxt;
            r_frame  <= w_frame_nxt;
        end
    end

    // A write is dropped only when full and no slot is freed this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_wr && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign ssp_clk   = r_sclk;
    assign ssp_frame = r_frame;
    assign ssp_din   = ssp_first_bit(r_shift);
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lf_sample_ssp_tx.sv
// Directed bench for lf_sample_ssp_tx: an ARM-side monitor rebuilds bytes
// from ssp_clk rises and the directed steps compare them with hand values.
module tb_lf_sample_ssp_tx;
    import lf_sample_ssp_tx_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       data_rdy;
    logic [7:0] adc_filtered;
    logic       ssp_clk;
    logic       ssp_frame;
    logic       ssp_din;
    logic [2:0] fifo_level;
    logic       overflow;
    ssp_state_t dbg_state;

    int         n_asrt = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         max_level = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] fp_q[$];
    int         fs_q[$];

    logic [7:0] mon_sr = '0;
    logic [7:0] mon_fp = '0;
    int         mon_cnt = 0;
    logic       prev_sclk = 1'b0;
    logic       prev_frame = 1'b0;

    lf_sample_ssp_tx #(
        .DEPTH   (4),
        .SSP_DIV (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .data_rdy     (data_rdy),
        .adc_filtered (adc_filtered),
        .ssp_clk      (ssp_clk),
        .ssp_frame    (ssp_frame),
        .ssp_din      (ssp_din),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ARM-side receiver: samples ssp_din on each ssp_clk rise.
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            mon_cnt    = 0;
            prev_sclk  = 1'b0;
            prev_frame = 1'b0;
        end else begin
            if (ssp_clk && !prev_sclk) begin
                if (ssp_frame) mon_cnt = 0;
                mon_sr = {mon_sr[6:0], ssp_din};
                mon_fp = {mon_fp[6:0], ssp_frame};
                mon_cnt++;
                if (mon_cnt == 8) begin
                    rx_q.push_back(mon_sr);
                    fp_q.push_back(mon_fp);
                    mon_cnt = 0;
                end
            end
            if (ssp_frame && !prev_frame) fs_q.push_back(cyc);
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            prev_sclk  = ssp_clk;
            prev_frame = ssp_frame;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [7:0] b);
        data_rdy     = 1'b1;
        adc_filtered = b;
        @(negedge clk);
        data_rdy     = 1'b0;
    endtask

    task automatic clear_q();
        exp_q.delete();
        rx_q.delete();
        fp_q.delete();
        fs_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(dbg_state == ST_IDLE && fifo_level == 3'd0 && !ssp_clk) && n < 600) begin
            @(negedge clk);
            n++;
        end
        step(2);
        check({tag, "_drain"}, 32'(n < 600), 32'd1);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) check({tag, "_byte"}, rx_q[i], exp_q[i]);
        end
        for (int i = 0; i < fp_q.size(); i++) begin
            check({tag, "_frame_bits"}, fp_q[i], 8'h80);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(2);
    endtask

    initial begin
        logic [7:0] v;
        reset        = 1'b1;
        enable       = 1'b1;
        data_rdy     = 1'b0;
        adc_filtered = 8'h00;

        // Reset state
        step(2);
        check("rst_sclk", ssp_clk, 1'b0);
        check("rst_frame", ssp_frame, 1'b0);
        check("rst_din", ssp_din, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);
        reset = 1'b0;
        step(2);

        // Single sample 0xA5
        clear_q();
        exp_q.push_back(8'hA5);
        strobe(8'hA5);
        check("single_level_after_push", fifo_level, 3'd1);
        check("single_frame_before_pop", ssp_frame, 1'b0);
        step(1);
        check("single_frame_load", ssp_frame, 1'b1);
        check("single_din_msb", ssp_din, 1'b1);
        check("single_sclk_load", ssp_clk, 1'b0);
        check("single_level_popped", fifo_level, 3'd0);
        check("single_state_shift", dbg_state, ST_SHIFT);
        step(15);
        check("single_state_cyc15", dbg_state, ST_SHIFT);
        step(1);
        check("single_state_cyc16", dbg_state, ST_IDLE);
        check("single_idle_sclk", ssp_clk, 1'b0);
        check("single_idle_frame", ssp_frame, 1'b0);
        check("single_idle_din", ssp_din, 1'b0);
        step(2);
        check_rx("single");

        // 1 MSa stream, one strobe every 24 cycles
        clear_q();
        max_level = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 0)      v = 8'h00;
            else if (i == 1) v = 8'hFF;
            else if (i == 2) v = 8'h3C;
            else             v = 8'($urandom_range(0, 255));
            exp_q.push_back(v);
            strobe(v);
            step(23);
        end
        wait_idle("stream");
        check_rx("stream");
        check("stream_ovf", overflow, 1'b0);
        check("stream_max_level_le1", 32'(max_level <= 1), 32'd1);

        // Burst of six consecutive strobes into a depth-4 FIFO
        clear_q();
        for (int k = 1; k <= 6; k++) begin
            if (k <= 5) exp_q.push_back(8'(k * 8'h11));
            strobe(8'(k * 8'h11));
        end
        check("burst_level_full", fifo_level, 3'd4);
        check("burst_ovf_set", overflow, 1'b1);
        wait_idle("burst");
        check_rx("burst");
        check("burst_frame_count", fs_q.size(), 5);
        for (int i = 1; i < fs_q.size(); i++) begin
            check("burst_frame_spacing", fs_q[i] - fs_q[i-1], 16);
        end
        check("burst_ovf_sticky", overflow, 1'b1);
        do_reset();
        check("burst_ovf_cleared", overflow, 1'b0);

        // Full FIFO with a write coinciding with the byte-boundary pop
        clear_q();
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(8'hA0 + 8'(k));
            strobe(8'hA0 + 8'(k));
        end
        check("fullpop_level_full", fifo_level, 3'd4);
        step(12);
        check("fullpop_sclk_high", ssp_clk, 1'b1);
        check("fullpop_level_before", fifo_level, 3'd4);
        exp_q.push_back(8'hA6);
        strobe(8'hA6);
        check("fullpop_level_kept", fifo_level, 3'd4);
        check("fullpop_ovf_clear", overflow, 1'b0);
        check("fullpop_frame_next", ssp_frame, 1'b1);
        wait_idle("fullpop");
        check_rx("fullpop");

        // Disable mid-byte with two samples queued
        clear_q();
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(8'hB0 + 8'(k));
            strobe(8'hB0 + 8'(k));
        end
        check("disable_level_queued", fifo_level, 3'd2);
        step(4);
        enable = 1'b0;
        strobe(8'hB4);
        check("disable_level_ignored", fifo_level, 3'd2);
        step(3);
        strobe(8'hB5);
        wait_idle("disable");
        check_rx("disable");
        check("disable_ovf", overflow, 1'b0);
        enable = 1'b1;

        // Reset asserted during bit 3
        clear_q();
        strobe(8'h5A);
        strobe(8'h77);
        step(9);
        check("midrst_sclk_pre", ssp_clk, 1'b1);
        check("midrst_din_pre", ssp_din, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_sclk", ssp_clk, 1'b0);
        check("midrst_din", ssp_din, 1'b0);
        check("midrst_frame", ssp_frame, 1'b0);
        check("midrst_level", fifo_level, 3'd0);
        check("midrst_state", dbg_state, ST_IDLE);
        step(2);
        reset = 1'b0;
        step(3);
        check("midrst_quiet_state", dbg_state, ST_IDLE);
        check("midrst_quiet_frame", ssp_frame, 1'b0);
        clear_q();
        exp_q.push_back(8'hC3);
        strobe(8'hC3);
        wait_idle("midrst");
        check_rx("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
